// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Radix-2 shift-add multiply and restoring divide on operand magnitudes.
//   Each operation takes exactly 32 iterations and is followed by one DONE cycle.
//   Signs are applied at the end by a conditional two's-complement negation.
//   Divide-by-zero and signed overflow are flagged when the operands are
//   captured, and their fixed results are forced in DONE.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, accepted only in IDLE
//   op[2:0]       RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b          rs1 / rs2 operands, captured on the accepting edge
//   busy          high in CALC and DONE
//   done          one-cycle pulse; result is valid in that cycle
//   result        registered result, held until the next DONE
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic [XLEN-1:0] hi;        // product high half / partial remainder
   logic [XLEN-1:0] lo;        // multiplier -> product low half / dividend -> quotient
   logic [XLEN-1:0] dvs;       // multiplicand or divisor magnitude
   logic            neg_q;     // negate the final value
   logic            spec_q;    // special case, result forced
   logic [XLEN-1:0] spec_val_q;

   // ---------------- capture-side decode ----------------
   logic            a_sgn, b_sgn, sa, sb, neg_in, div0, ovf;
   logic [XLEN-1:0] a_mag, b_mag, spec_in;

   always_comb begin
      // Divide ops: DIV/REM signed (op[0]=0). Multiply: MULH both, MULHSU a only.
      a_sgn   = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
      b_sgn   = op[2] ? ~op[0] : (op[1:0] == 2'b01);
      sa      = a_sgn & a[XLEN-1];
      sb      = b_sgn & b[XLEN-1];
      a_mag   = sa ? -a : a;
      b_mag   = sb ? -b : b;
      // Remainder follows the dividend; product and quotient follow sa^sb.
      neg_in  = (op[2] & op[1]) ? sa : (sa ^ sb);
      div0    = op[2] && (b == '0);
      ovf     = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
      spec_in = '0;
      if (div0)
         spec_in = op[1] ? a : '1;
      else if (ovf)
         spec_in = op[1] ? '0 : MIN_NEG;
   end

   // ---------------- one iteration ----------------
   logic [XLEN:0]     m_sum;
   logic [XLEN-1:0]   m_hi, m_lo;
   logic [XLEN:0]     d_sh;
   logic              d_ge;
   logic [XLEN-1:0]   d_hi, d_lo;
   logic [2*XLEN-1:0] p_s;
   logic [XLEN-1:0]   q_s, r_s, fin;

   always_comb begin
      // multiply: add multiplicand when the current multiplier bit is set, shift right
      m_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
      m_hi  = m_sum[XLEN:1];
      m_lo  = {m_sum[0], lo[XLEN-1:1]};
      // restoring divide: bring in next dividend bit, subtract if it fits.
      // The true difference is below the divisor, so XLEN bits are enough.
      d_sh  = {hi, lo[XLEN-1]};
      d_ge  = (d_sh >= {1'b0, dvs});
      d_hi  = d_ge ? (d_sh[XLEN-1:0] - dvs) : d_sh[XLEN-1:0];
      d_lo  = {lo[XLEN-2:0], d_ge};
      // sign fix-up, only meaningful on the last iteration
      p_s   = neg_q ? -{m_hi, m_lo} : {m_hi, m_lo};
      q_s   = neg_q ? -d_lo : d_lo;
      r_s   = neg_q ? -d_hi : d_hi;
      if (spec_q)
         fin = spec_val_q;
      else if (op_q[2])
         fin = op_q[1] ? r_s : q_s;
      else
         fin = (op_q[1:0] == 2'b00) ? p_s[XLEN-1:0] : p_s[2*XLEN-1:XLEN];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         op_q       <= '0;
         hi         <= '0;
         lo         <= '0;
         dvs        <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         result     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt        <= CW'(XLEN-1);
               op_q       <= op;
               hi         <= '0;
               lo         <= a_mag;
               dvs        <= b_mag;
               neg_q      <= neg_in;
               spec_q     <= div0 | ovf;
               spec_val_q <= spec_in;
            end
            CALC: begin
               hi  <= op_q[2] ? d_hi : m_hi;
               lo  <= op_q[2] ? d_lo : m_lo;
               cnt <= cnt - 1'b1;
               if (cnt == '0) result <= fin;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model, including exact 32-cycle latency, ignored
// start during CALC, back-to-back issue, special cases and mid-run reset.
module tb_muldiv_unit;

   logic        clk, rst, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      int sx, sy;
      sx = x;
      sy = y;
      case (o)
         3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
         3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
         3'd2: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
         3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sx / sy);
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sx % sy);
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op and check busy/done/result cycle by cycle. If inj is 1..31,
   // a start with junk operands is pulsed so that it is sampled at edge k+inj.
   task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int inj, input string tag);
      logic [31:0] exp;
      exp = ref_model(o, x, y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      chk(32'(busy), 32'd1, {tag, "_busy_k"});
      for (int i = 1; i <= 32; i++) begin
         if (i == inj) begin
            start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (i < 32) begin
            chk(32'(done), 32'd0, {tag, "_early_done"});
         end else begin
            chk(32'(done), 32'd1, {tag, "_done"});
            chk(32'(busy), 32'd1, {tag, "_busy_done"});
            chk(result, exp, {tag, "_result"});
         end
      end
      @(posedge clk); #1;
      chk(32'(done), 32'd0, {tag, "_done_clr"});
      chk(32'(busy), 32'd0, {tag, "_idle"});
      chk(result, exp, {tag, "_hold"});
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      bit          saw_done;

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      #3;
      chk(32'(busy), 32'd0, "rst_busy");
      chk(32'(done), 32'd0, "rst_done");
      chk(result, 32'd0, "rst_result");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // directed cases
      run(3'd0, 32'd7, 32'd6, 0, "mul_7x6");
      run(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_max");
      run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      run(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
      run(3'd5, 32'd100, 32'd7, 0, "divu_100_7");
      run(3'd7, 32'd100, 32'd7, 0, "remu_100_7");
      run(3'd4, 32'd5, 32'd0, 0, "div_by0");
      run(3'd6, 32'd5, 32'd0, 0, "rem_by0");
      run(3'd5, 32'd5, 32'd0, 0, "divu_by0");
      run(3'd7, 32'd5, 32'd0, 0, "remu_by0");
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

      // start during CALC is ignored; the next run starts in the first IDLE cycle
      run(3'd0, 32'd12345, 32'd678, 5, "ign_calc");
      run(3'd4, 32'hFFFF_FC00, 32'd3, 0, "b2b_div");

      // randomized against the model, with some special operands mixed in
      for (int n = 0; n < 24; n++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run(ro, ra, rb, (n % 4 == 0) ? int'($urandom_range(1, 31)) : 0, "rand");
      end

      // reset in the 10th CALC cycle aborts the operation
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk(32'(busy), 32'd0, "abort_busy");
      chk(32'(done), 32'd0, "abort_done");
      chk(result, 32'd0, "abort_result");
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      chk(32'(saw_done), 32'd0, "abort_no_done");
      run(3'd0, 32'd3, 32'd3, 0, "mul_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is required to be supported.
REQ-002 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request; sampled on rising edge of clk.
REQ-006 Port: op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: a  input  XLEN  rs1 operand, driven from register file rd1.
REQ-008 Port: b  input  XLEN  rs2 operand, driven from register file rd2.
REQ-009 Port: busy  output  1  high while an operation is in progress (states CALC and DONE).
REQ-010 Port: done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 Port: result  output  XLEN  operation result, feeds register file write data wd3.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE; these are the only states.
REQ-013 IDLE: start=1 at edge k SHALL capture op, a, b, load the iteration counter with 31, and enter CALC.
REQ-014 start SHALL be ignored in CALC and DONE; captured operands are unaffected by input changes after edge k.
REQ-015 CALC: one radix-2 iteration per edge (shift-add multiply / restoring divide on operand magnitudes).
REQ-016 CALC: the iteration performed with counter==0 SHALL transition to DONE; edges k+1..k+32 are iterations.
REQ-017 DONE (the cycle after edge k+32): done=1, result valid; the next edge SHALL return the FSM to IDLE.
REQ-018 Latency SHALL be fixed at 32 cycles from the capture edge to done for all ops, including special cases.
REQ-019 A start in the first IDLE cycle after DONE SHALL be accepted (back-to-back throughput 34 cycles).
REQ-020 result SHALL hold its last value from the DONE cycle until the next DONE; done=0 outside DONE.
REQ-021 Signed ops SHALL use magnitudes, forming a 64-bit unsigned product or a quotient/remainder, then a conditional two's-complement negation.
REQ-022 MUL: low 32 bits; MULH: high 32, signed x signed; MULHSU: high 32, a signed x b unsigned; MULHU: high 32, unsigned.
REQ-023 DIV/DIVU: quotient truncated toward zero; REM/REMU: remainder takes the sign of the dividend.
REQ-024 Divide by zero (b=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
REQ-025 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-026 Special cases SHALL be detected at capture and forced in DONE, still after 32 cycles.
REQ-027 The block SHALL contain no combinational path from inputs to outputs; all outputs SHALL be registered.

Reset
REQ-028 rst=1 SHALL immediately set state=IDLE, busy=0, done=0, result=0, counter=0 and all datapath registers to 0.
REQ-029 rst asserted during CALC or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-030 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031 MUL a=7 b=6, start at edge k -> busy=1 from k; done=1, result=42 exactly in the cycle after edge k+32; then busy=0.
REQ-032 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all with 32-cycle latency.
REQ-035 start pulsed with new operands during CALC -> ignored, original result delivered; start in the IDLE cycle after DONE -> accepted.
REQ-036 rst at the 10th CALC cycle -> busy=0, result=0 immediately; no done pulse within 40 cycles; a new MUL 3*3 then returns 9.
